// File: rtl/diff_serial_tx_pkg.sv
// Shared definitions for the differential serial transmitter: FSM state
// encoding, parity-mode constants and a frame-length helper.
package diff_serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Bit periods in one frame: start + payload + optional parity + stop.
    function automatic int frame_bits(input int data_width, input int par_mode);
        return 2 + data_width + ((par_mode != PAR_NONE) ? 1 : 0);
    endfunction

endpackage

// File: rtl/diff_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit period with a one-cycle tick.
module diff_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk_sys,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

    logic [7:0] cnt;

    assign tick = en && (cnt == LAST);

    // Count restarts at every bit boundary and sits at zero while idle.
    always_ff @(posedge clk_sys) begin
        if (rst || !en || tick) begin
            cnt <= 8'd0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/diff_serial_tx.sv
// Differential serial transmitter: frames a payload word as start bit,
// LSB-first data, optional parity and stop bit on a true/complement pair.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | line at mark (O=1), ready to accept a word
//   START | start bit (O=0)
//   DATA  | payload bits, LSB first, one per bit period
//   PAR   | parity bit (only when PARITY is not "NONE")
//   STOP  | stop bit (O=1), then back to IDLE
module diff_serial_tx
    import diff_serial_tx_pkg::*;
#(
    parameter int    CLKS_PER_BIT = 4,
    parameter int    DATA_WIDTH   = 8,
    parameter string PARITY       = "NONE",
    parameter string IOSTANDARD   = "LVDS_25"
) (
    input  logic                  C,
    input  logic                  R,
    input  logic [DATA_WIDTH-1:0] DIN,
    input  logic                  DVALID,
    output logic                  DREADY,
    output logic                  BUSY,
    output logic                  O,
    output logic                  OB
);

    localparam int         PAR_MODE = (PARITY == "EVEN") ? PAR_EVEN :
                                      (PARITY == "ODD")  ? PAR_ODD  : PAR_NONE;
    localparam logic       PAR_INV  = (PAR_MODE == PAR_ODD);
    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    // Reject out-of-range configurations at elaboration; the I/O standard
    // is only a placement attribute and must merely be named.
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 255) begin : g_bad_cpb
        $error("diff_serial_tx: CLKS_PER_BIT out of range");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_dw
        $error("diff_serial_tx: DATA_WIDTH out of range");
    end
    if (IOSTANDARD.len() == 0) begin : g_bad_iostd
        $error("diff_serial_tx: IOSTANDARD must be named");
    end

    tx_state_e             state, state_n;
    logic [DATA_WIDTH-1:0] shift_q, shift_n;
    logic [3:0]            bit_cnt, bit_cnt_n;
    logic                  par_q, par_n;
    logic                  o_q, ob_q, o_n;
    logic                  tick;
    logic                  accept;

    assign DREADY = (state == IDLE) && !R;
    assign BUSY   = (state != IDLE);
    assign accept = DVALID && DREADY;
    assign O      = o_q;
    assign OB     = ob_q;

    diff_tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk_sys(C),
        .rst    (R),
        .en     (BUSY),
        .tick   (tick)
    );

    // Next-state, datapath and next line level; the line level follows the
    // next state so O changes on the same edge as the state.
    always_comb begin
        state_n   = state;
        shift_n   = shift_q;
        bit_cnt_n = bit_cnt;
        par_n     = par_q;
        o_n       = 1'b1;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n   = START;
                    shift_n   = DIN;
                    bit_cnt_n = 4'd0;
                    par_n     = (^DIN) ^ PAR_INV;
                end
            end
            START: begin
                if (tick) state_n = DATA;
            end
            DATA: begin
                if (tick) begin
                    shift_n   = {1'b0, shift_q[DATA_WIDTH-1:1]};
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == LAST_BIT) begin
                        state_n = (PAR_MODE != PAR_NONE) ? PAR : STOP;
                    end
                end
            end
            PAR: begin
                if (tick) state_n = STOP;
            end
            STOP: begin
                if (tick) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        case (state_n)
            START:   o_n = 1'b0;
            DATA:    o_n = shift_n[0];
            PAR:     o_n = par_n;
            default: o_n = 1'b1;
        endcase
    end

    // State, datapath and output pair registers with synchronous reset.
    always_ff @(posedge C) begin
        if (R) begin
            state   <= IDLE;
            shift_q <= '0;
            bit_cnt <= 4'd0;
            par_q   <= 1'b0;
            o_q     <= 1'b1;
            ob_q    <= 1'b0;
        end else begin
            state   <= state_n;
            shift_q <= shift_n;
            bit_cnt <= bit_cnt_n;
            par_q   <= par_n;
            o_q     <= o_n;
            ob_q    <= ~o_n;
        end
    end

endmodule
